// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// The CPU side is served from the arrays combinationally. A miss freezes the pipe
// through cpu_stall_o while the 256-bit block port writes back a dirty victim,
// then refills the line.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | serving hits; a miss latches its tag and index and leaves IDLE
// WB    | writing the dirty victim block back to memory, waiting for ack
// ALLOC | reading the missing block from memory, waiting for ack
// FILL  | one bubble cycle so the frozen access replays as a hit

module dcache_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o
);

    localparam int TAG_W = 32 - 5 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [255:0]     r_data [LINES];

    logic [TAG_W-1:0]   r_miss_tag;
    logic [INDEX_W-1:0] r_miss_idx;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [2:0]         w_word;
    logic [7:0]         w_bit;
    logic               w_req;
    logic               w_hit;
    logic               w_miss;
    logic               w_wr_hit;
    logic               w_fill;

    assign w_tag  = cpu_addr_i[31:5+INDEX_W];
    assign w_idx  = cpu_addr_i[4+INDEX_W:5];
    assign w_word = cpu_addr_i[4:2];
    assign w_bit  = {w_word, 5'b0};
    assign w_req  = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // The CPU side is only looked at in IDLE; elsewhere the pipe is frozen.
    assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;
    assign w_wr_hit = (r_state == S_IDLE) && cpu_MemWrite_i && w_hit;
    assign w_fill   = (r_state == S_ALLOC) && mem_ack_i;

    assign cpu_stall_o = w_miss || (r_state != S_IDLE);

    // A store wins when both requests are raised, so a read hit needs MemWrite low.
    assign cpu_data_o = ((r_state == S_IDLE) && cpu_MemRead_i && !cpu_MemWrite_i && w_hit)
                        ? r_data[w_idx][w_bit +: 32] : 32'd0;

    // State register and miss latch; the latch only loads on the IDLE exit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss) begin
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
            end
        end
    end

    // Next-state and memory-port outputs; outputs stay fixed for the whole wait.
    always_comb begin
        w_next_state = r_state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        case (r_state)
            S_IDLE: begin
                if (w_miss)
                    w_next_state = r_dirty[w_idx] ? S_WB : S_ALLOC;
            end
            S_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_tag[r_miss_idx], r_miss_idx, 5'b0};
                mem_data_o   = r_data[r_miss_idx];
                if (mem_ack_i)
                    w_next_state = S_ALLOC;
            end
            S_ALLOC: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {r_miss_tag, r_miss_idx, 5'b0};
                if (mem_ack_i)
                    w_next_state = S_FILL;
            end
            S_FILL: begin
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Valid/dirty bits: cleared on reset, set by refill, dirty set by store hits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays have no reset; valid bits guard their contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_fill) begin
                r_tag[r_miss_idx]  <= r_miss_tag;
                r_data[r_miss_idx] <= mem_data_i;
            end else if (w_wr_hit) begin
                r_data[w_idx][w_bit +: 32] <= cpu_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs change and outputs are sampled on the
// falling edge, memory acks are hand-driven one cycle at a time.

module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    int checks = 0;
    int errors = 0;

    logic [255:0] blk1;
    logic [255:0] blk2;
    logic [255:0] blk3;
    logic [255:0] blk5;

    dcache_ctrl #(.INDEX_W(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mk_blk(input logic [31:0] base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++)
            b[k*32 +: 32] = base + 32'(k);
        return b;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        #1;
    endtask

    initial begin
        blk1 = mk_blk(32'h1000_0000);
        blk1[95:64] = 32'hDEAD_BEEF;
        blk2 = mk_blk(32'h2000_0000);
        blk3 = mk_blk(32'h3000_0000);
        blk5 = mk_blk(32'h5000_0000);

        rst_i = 1'b1;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk_i);
        tick();
        tick();

        // reset state
        check("rst_stall",  cpu_stall_o,  1'b0);
        check("rst_en",     mem_enable_o, 1'b0);
        check("rst_wr",     mem_write_o,  1'b0);
        check("rst_data",   cpu_data_o,   32'd0);
        check("rst_addr",   mem_addr_o,   32'd0);
        check("rst_mdata",  mem_data_o,   256'd0);
        rst_i = 1'b0;
        tick();

        // T1: read miss on clean line, refill after five cycles
        cpu(1'b1, 1'b0, 32'h40, 32'd0);
        check("t1_stall_miss", cpu_stall_o, 1'b1);
        tick();
        check("t1_alloc_en",   mem_enable_o, 1'b1);
        check("t1_alloc_wr",   mem_write_o,  1'b0);
        check("t1_alloc_addr", mem_addr_o,   32'h40);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t1_alloc_hold", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h40});
        end
        mem_ack_i = 1'b1;
        mem_data_i = blk1;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        #1;
        check("t1_fill_en",    mem_enable_o, 1'b0);
        check("t1_fill_stall", cpu_stall_o,  1'b1);
        tick();
        check("t1_replay_stall", cpu_stall_o, 1'b0);
        check("t1_replay_data",  cpu_data_o,  32'h1000_0000);
        cpu(1'b1, 1'b0, 32'h48, 32'd0);
        check("t1_hit_data",  cpu_data_o,  32'hDEAD_BEEF);
        check("t1_hit_stall", cpu_stall_o, 1'b0);

        // T2: store hit then load same word
        cpu(1'b0, 1'b1, 32'h44, 32'h1234_5678);
        check("t2_store_stall", cpu_stall_o, 1'b0);
        check("t2_store_data0", cpu_data_o,  32'd0);
        tick();
        cpu(1'b1, 1'b0, 32'h44, 32'd0);
        check("t2_load_data",  cpu_data_o,  32'h1234_5678);
        check("t2_load_stall", cpu_stall_o, 1'b0);

        // T3: conflict miss on dirty line -> write-back then refill
        cpu(1'b1, 1'b0, 32'h244, 32'd0);
        check("t3_stall", cpu_stall_o, 1'b1);
        tick();
        check("t3_wb_ctl",  {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b1, 32'h40});
        check("t3_wb_w1",   mem_data_o[63:32], 32'h1234_5678);
        check("t3_wb_w2",   mem_data_o[95:64], 32'hDEAD_BEEF);
        check("t3_wb_w0",   mem_data_o[31:0],  32'h1000_0000);
        tick();
        check("t3_wb_hold", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b1, 32'h40});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t3_alloc_ctl", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h240});
        mem_ack_i = 1'b1;
        mem_data_i = blk2;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        #1;
        check("t3_fill", {cpu_stall_o, mem_enable_o}, {1'b1, 1'b0});
        tick();
        check("t3_replay", {cpu_stall_o, cpu_data_o}, {1'b0, 32'h2000_0001});

        // T4: store miss to clean line -> refill only, then merged word
        cpu(1'b0, 1'b1, 32'h64, 32'hCAFE_F00D);
        check("t4_stall", cpu_stall_o, 1'b1);
        tick();
        check("t4_alloc_ctl", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h60});
        mem_ack_i = 1'b1;
        mem_data_i = blk3;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        #1;
        check("t4_fill_wr", {mem_write_o, cpu_stall_o}, {1'b0, 1'b1});
        tick();
        check("t4_replay_stall", cpu_stall_o, 1'b0);
        tick();
        cpu(1'b1, 1'b0, 32'h64, 32'd0);
        check("t4_merged", cpu_data_o, 32'hCAFE_F00D);
        cpu(1'b1, 1'b0, 32'h60, 32'd0);
        check("t4_other_word", cpu_data_o, 32'h3000_0000);
        // eviction of line 3 must write back, proving dirty was set by the replay
        cpu(1'b1, 1'b0, 32'h264, 32'd0);
        tick();
        check("t4_dirty_wb", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b1, 32'h60});
        check("t4_wb_word", mem_data_o[63:32], 32'hCAFE_F00D);

        // T5: reset during write-back wait aborts and clears valid bits
        rst_i = 1'b1;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("t5_abort", {mem_enable_o, cpu_stall_o, mem_write_o}, 3'b000);
        rst_i = 1'b0;
        tick();
        cpu(1'b1, 1'b0, 32'h244, 32'd0);
        check("t5_now_miss", {cpu_stall_o, cpu_data_o}, {1'b1, 32'd0});
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        check("t5_no_req_stall", cpu_stall_o, 1'b0);

        // T6: spurious ack in IDLE is ignored
        mem_ack_i = 1'b1;
        mem_data_i = blk5;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        tick();
        check("t6_idle_ack", {mem_enable_o, cpu_stall_o}, 2'b00);
        cpu(1'b1, 1'b0, 32'hA4, 32'd0);
        check("t6_still_miss", cpu_stall_o, 1'b1);

        // T6: read+write together behaves as a store
        cpu(1'b1, 1'b1, 32'hA4, 32'h55AA_55AA);
        tick();
        check("t6_alloc_ctl", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'hA0});
        mem_ack_i = 1'b1;
        mem_data_i = blk5;
        tick();
        // an ack held into FILL must not restart anything
        mem_data_i = '0;
        #1;
        check("t6_fill", {cpu_stall_o, mem_enable_o}, 2'b10);
        mem_ack_i = 1'b0;
        tick();
        check("t6_replay", {cpu_stall_o, cpu_data_o}, {1'b0, 32'd0});
        tick();
        cpu(1'b1, 1'b0, 32'hA4, 32'd0);
        check("t6_store_data", cpu_data_o, 32'h55AA_55AA);
        cpu(1'b1, 1'b0, 32'hA8, 32'd0);
        check("t6_neighbour", cpu_data_o, 32'h5000_0002);
        cpu(1'b1, 1'b0, 32'h2A4, 32'd0);
        tick();
        check("t6_dirty_wb", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b1, 32'hA0});

        rst_i = 1'b1;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
